axi_rd_arbiter_n: RTL and testbench

Parametrised N-master AXI read-channel arbiter with round-robin fairness and burst support. It sits between the instruction/data fetch masters (IFU, LSU, and later DMA/debug) and the single AXI read port toward the crossbar/SRAM. The grant is registered and held for one complete AR+R burst, so the grant cannot change mid-transaction. A beat counter checks `rlast` against the granted `arlen`.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_rr_picker.sv | 29 ++
 rtl/axi_rd_arbiter_n.sv | 127 ++++++++++++
 tb/tb_axi_rd_arbiter_n.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read-path arbiter: response codes, arbiter
// state encoding and the default burst-length width.
package axi_pkg;

    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_mst_resp_t;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        ARB_AR   = 3'b010,
        ARB_R    = 3'b100
    } arb_state_t;

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: the first requester found searching
// upward from ptr+1 (modulo N) wins.
module axi_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest slot down so the slot nearest ptr+1 is written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter_n.sv
// N-master AXI read-channel arbiter: round-robin grant held for one whole
// AR+R burst, with an rlast-versus-arlen beat check.
module axi_rd_arbiter_n
    import axi_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = AXI_LEN_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MST-1:0]        s_ar_valid_i,
    input  logic [NUM_MST*ADDR_W-1:0] s_ar_addr_i,
    input  logic [NUM_MST*LEN_W-1:0]  s_ar_len_i,
    output logic [NUM_MST-1:0]        s_ar_ready_o,
    output logic [NUM_MST-1:0]        s_r_valid_o,
    output logic [DATA_W-1:0]         s_r_data_o,
    output axi_mst_resp_t             s_r_resp_o,
    output logic                      s_r_last_o,
    input  logic [NUM_MST-1:0]        s_r_ready_i,
    output logic                      m_ar_valid_o,
    output logic [ADDR_W-1:0]         m_ar_addr_o,
    output logic [LEN_W-1:0]          m_ar_len_o,
    input  logic                      m_ar_ready_i,
    input  logic                      m_r_valid_i,
    input  logic [DATA_W-1:0]         m_r_data_i,
    input  axi_mst_resp_t             m_r_resp_i,
    input  logic                      m_r_last_i,
    output logic                      m_r_ready_o,
    output logic                      busy_o,
    output logic                      len_err_o
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, ptr_q, pick_idx;
    logic             pick_vld;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_cnt_q;
    logic             r_hs, beat_at_len;

    axi_rr_picker #(.N(NUM_MST), .IDX_W(IDX_W)) u_picker (
        .req     (s_ar_valid_i),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign r_hs        = (state_q == ARB_R) && m_r_valid_i && s_r_ready_i[grant_q];
    assign beat_at_len = (beat_cnt_q == {1'b0, len_q});
    assign busy_o      = (state_q != ARB_IDLE);

    // Reset leaves ptr on the last master so master 0 is the first winner.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= IDX_W'(NUM_MST - 1);
            grant_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && pick_vld) begin
                grant_q    <= pick_idx;
                len_q      <= s_ar_len_i[int'(pick_idx)*LEN_W +: LEN_W];
                beat_cnt_q <= '0;
            end
            if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                if (m_r_last_i) begin
                    ptr_q <= grant_q;
                end
            end
        end
    end

    // Only the granted master sees the channel, and only in the matching state.
    always_comb begin
        state_d      = state_q;
        s_ar_ready_o = '0;
        s_r_valid_o  = '0;
        s_r_data_o   = '0;
        s_r_resp_o   = AXI_RESP_OKAY;
        s_r_last_o   = 1'b0;
        m_ar_valid_o = 1'b0;
        m_ar_addr_o  = '0;
        m_ar_len_o   = '0;
        m_r_ready_o  = 1'b0;
        len_err_o    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_AR;
                end
            end
            ARB_AR: begin
                m_ar_valid_o          = s_ar_valid_i[grant_q];
                m_ar_addr_o           = s_ar_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
                m_ar_len_o            = s_ar_len_i[int'(grant_q)*LEN_W +: LEN_W];
                s_ar_ready_o[grant_q] = m_ar_ready_i;
                if (s_ar_valid_i[grant_q] && m_ar_ready_i) begin
                    state_d = ARB_R;
                end
            end
            ARB_R: begin
                s_r_valid_o[grant_q] = m_r_valid_i;
                s_r_data_o           = m_r_data_i;
                s_r_resp_o           = m_r_resp_i;
                s_r_last_o           = m_r_last_i;
                m_r_ready_o          = s_r_ready_i[grant_q];
                // A beat past the granted length without rlast keeps us in R until rlast.
                if (r_hs) begin
                    if (m_r_last_i) begin
                        state_d   = ARB_IDLE;
                        len_err_o = !beat_at_len;
                    end else begin
                        len_err_o = beat_at_len;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// Self-checking bench for axi_rd_arbiter_n: master/slave models on the falling
// edge, expected R beats queued at request time and matched against observed beats.
module tb_axi_rd_arbiter_n;
    import axi_pkg::*;

    localparam int NM = 4;

    typedef struct packed {
        logic [1:0]  mst;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        lerr;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_i = 1'b0;
    logic [NM-1:0]      s_ar_valid_i = '0;
    logic [NM*32-1:0]   s_ar_addr_i = '0;
    logic [NM*8-1:0]    s_ar_len_i = '0;
    logic [NM-1:0]      s_ar_ready_o;
    logic [NM-1:0]      s_r_valid_o;
    logic [63:0]        s_r_data_o;
    axi_mst_resp_t      s_r_resp_o;
    logic               s_r_last_o;
    logic [NM-1:0]      s_r_ready_i = '0;
    logic               m_ar_valid_o;
    logic [31:0]        m_ar_addr_o;
    logic [7:0]         m_ar_len_o;
    logic               m_ar_ready_i = 1'b0;
    logic               m_r_valid_i = 1'b0;
    logic [63:0]        m_r_data_i = '0;
    axi_mst_resp_t      m_r_resp_i = AXI_RESP_OKAY;
    logic               m_r_last_i = 1'b0;
    logic               m_r_ready_o;
    logic               busy_o;
    logic               len_err_o;

    int          checks = 0;
    int          errors = 0;

    int          req_left [NM] = '{default: 0};
    logic [31:0] req_addr [NM] = '{default: 32'h0};
    logic [7:0]  req_len  [NM] = '{default: 8'h0};
    bit          rdy_hold [NM] = '{default: 1'b0};
    bit          r_stall_rand = 1'b0;
    bit          rdy_rand = 1'b0;
    int          last_override = 0;

    bit          slv_active = 1'b0;
    int          slv_mst = 0;
    logic [31:0] slv_addr = '0;
    int          slv_beat = 0;
    int          slv_total = 0;
    int          ar_pend = -1;
    logic [31:0] pend_addr = '0;
    logic [7:0]  pend_len = '0;
    bit          r_pend = 1'b0;
    bit          rst_pend = 1'b0;
    int          cyc = 0;
    int          ar_order[$];
    int          ar_cyc[$];
    int          r_last_cyc [NM] = '{default: 0};
    int          lerr_cnt = 0;
    int          xfer_viol = 0;
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    beat_t       exp_b, got_b, tmp_b;

    axi_rd_arbiter_n #(
        .NUM_MST (NM),
        .ADDR_W  (32),
        .DATA_W  (64),
        .LEN_W   (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .s_ar_valid_i (s_ar_valid_i),
        .s_ar_addr_i  (s_ar_addr_i),
        .s_ar_len_i   (s_ar_len_i),
        .s_ar_ready_o (s_ar_ready_o),
        .s_r_valid_o  (s_r_valid_o),
        .s_r_data_o   (s_r_data_o),
        .s_r_resp_o   (s_r_resp_o),
        .s_r_last_o   (s_r_last_o),
        .s_r_ready_i  (s_r_ready_i),
        .m_ar_valid_o (m_ar_valid_o),
        .m_ar_addr_o  (m_ar_addr_o),
        .m_ar_len_o   (m_ar_len_o),
        .m_ar_ready_i (m_ar_ready_i),
        .m_r_valid_i  (m_r_valid_i),
        .m_r_data_i   (m_r_data_i),
        .m_r_resp_i   (m_r_resp_i),
        .m_r_last_i   (m_r_last_i),
        .m_r_ready_o  (m_r_ready_o),
        .busy_o       (busy_o),
        .len_err_o    (len_err_o)
    );

    always #5 clk = ~clk;

    function automatic beat_t make_beat(input int mst, input logic [31:0] addr, input int idx,
                                        input bit last, input bit lerr);
        beat_t b;
        b.mst  = 2'(mst);
        b.data = {addr, 32'(idx)};
        b.resp = 2'(idx);
        b.last = last;
        b.lerr = lerr;
        return b;
    endfunction

    function automatic int reqs_left();
        int s = 0;
        for (int k = 0; k < NM; k++) s += req_left[k];
        return s;
    endfunction

    // Master and slave models: apply the handshakes of the coming edge, drive, then predict the next edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_pend) slv_active = 1'b0;
        if (r_pend) begin
            if (slv_beat == slv_total - 1) slv_active = 1'b0;
            else slv_beat++;
        end
        if (ar_pend >= 0) begin
            slv_active = 1'b1;
            slv_mst    = ar_pend;
            slv_addr   = pend_addr;
            slv_beat   = 0;
            slv_total  = (last_override > 0) ? last_override : int'(pend_len) + 1;
            req_left[ar_pend]--;
            req_addr[ar_pend] += 32'h100;
        end
        for (int k = 0; k < NM; k++) begin
            s_ar_valid_i[k]         = (req_left[k] > 0);
            s_ar_addr_i[k*32 +: 32] = req_addr[k];
            s_ar_len_i[k*8 +: 8]    = req_len[k];
            s_r_ready_i[k]          = !rdy_hold[k] && !(rdy_rand && $urandom_range(0, 1) == 0);
        end
        m_ar_ready_i = 1'b1;
        m_r_valid_i  = slv_active && !(r_stall_rand && $urandom_range(0, 2) == 0);
        m_r_data_i   = {slv_addr, 32'(slv_beat)};
        m_r_resp_i   = axi_mst_resp_t'(2'(slv_beat));
        m_r_last_i   = slv_active && (slv_beat == slv_total - 1);
        #2;
        rst_pend = !rst_i;
        ar_pend  = -1;
        r_pend   = 1'b0;
        if (rst_i) begin
            if (m_ar_valid_o && m_ar_ready_i) begin
                for (int k = 0; k < NM; k++) begin
                    if (s_ar_valid_i[k] && s_ar_ready_o[k]) ar_pend = k;
                end
                pend_addr = m_ar_addr_o;
                pend_len  = m_ar_len_o;
                ar_order.push_back(ar_pend);
                ar_cyc.push_back(cyc);
            end
            r_pend = m_r_valid_i && m_r_ready_o;
            for (int k = 0; k < NM; k++) begin
                if (s_r_valid_o[k] && s_r_ready_i[k]) begin
                    tmp_b.mst  = 2'(k);
                    tmp_b.data = s_r_data_o;
                    tmp_b.resp = s_r_resp_o;
                    tmp_b.last = s_r_last_o;
                    tmp_b.lerr = len_err_o;
                    obs_q.push_back(tmp_b);
                    if (s_r_last_o) r_last_cyc[k] = cyc;
                end
            end
            if (len_err_o) lerr_cnt++;
            if (s_r_valid_o != '0 && (!slv_active || s_r_valid_o != (NM'(1) << slv_mst))) xfer_viol++;
        end
    end

    task automatic wait_ar(input int n, output bit ok);
        for (int c = 0; c < 2000 && ar_order.size() < n; c++) begin
            @(posedge clk); #1;
        end
        ok = (ar_order.size() >= n);
    endtask

    task automatic wait_drain(output bit ok);
        for (int c = 0; c < 2000 && !(busy_o === 1'b0 && reqs_left() == 0 && obs_q.size() >= exp_q.size()); c++) begin
            @(posedge clk); #1;
        end
        ok = (busy_o === 1'b0 && reqs_left() == 0 && obs_q.size() >= exp_q.size());
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy_o); end
        checks++; if (m_ar_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_ar_valid got %b exp 0", m_ar_valid_o); end
        checks++; if (m_r_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_r_ready got %b exp 0", m_r_ready_o); end
        checks++; if (s_ar_ready_o !== 4'b0) begin errors++; $display("[TB] FAIL rst_s_ar_ready got %b exp 0000", s_ar_ready_o); end
        checks++; if (s_r_valid_o !== 4'b0) begin errors++; $display("[TB] FAIL rst_s_r_valid got %b exp 0000", s_r_valid_o); end
        checks++; if (len_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_len_err got %b exp 0", len_err_o); end
        rst_i = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        int lerr0;
        @(posedge clk); #1;
        lerr0 = lerr_cnt;
        req_addr[0] = 32'h8000_0000; req_len[0] = 8'd0; req_left[0] = 1;
        exp_q.push_back(make_beat(0, 32'h8000_0000, 0, 1'b1, 1'b0));
        @(posedge clk); #1;
        checks++; if (m_ar_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_ar_valid got %b exp 1", m_ar_valid_o); end
        checks++; if (m_ar_addr_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL single_ar_addr got %h exp 80000000", m_ar_addr_o); end
        checks++; if (s_ar_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL single_ar_ready got %b exp 0001", s_ar_ready_o); end
        @(posedge clk); #1;
        checks++; if (busy_o !== 1'b1 || m_ar_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_in_r busy %b ar_valid %b exp 1 0", busy_o, m_ar_valid_o); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout got busy %b exp idle", busy_o); end
        checks++; if (lerr_cnt - lerr0 !== 0) begin errors++; $display("[TB] FAIL single_len_err got %0d pulses exp 0", lerr_cnt - lerr0); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL single_beat got none exp %h", exp_b); end
            else begin got_b = obs_q.pop_front(); if (got_b !== exp_b) begin errors++; $display("[TB] FAIL single_beat got %h exp %h", got_b, exp_b); end end
        end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL single_extra got %0d beats exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_rotation();
        bit ok;
        int order [4] = '{0, 1, 0, 1};
        int nth [NM];
        int v0;
        do_reset();
        ar_order.delete(); ar_cyc.delete();
        v0 = xfer_viol;
        nth = '{default: 0};
        req_addr[0] = 32'h1000_0000; req_len[0] = 8'd1; req_left[0] = 2;
        req_addr[1] = 32'h2000_0000; req_len[1] = 8'd1; req_left[1] = 2;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = ((order[i] == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(nth[order[i]] * 'h100);
            nth[order[i]]++;
            exp_q.push_back(make_beat(order[i], a, 0, 1'b0, 1'b0));
            exp_q.push_back(make_beat(order[i], a, 1, 1'b1, 1'b0));
        end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rot_timeout got busy %b exp idle", busy_o); end
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (ar_order.size() > i) ? ar_order[i] : -1;
            checks++; if (g !== order[i]) begin errors++; $display("[TB] FAIL rot_grant%0d got %0d exp %0d", i, g, order[i]); end
        end
        checks++; if (xfer_viol - v0 !== 0) begin errors++; $display("[TB] FAIL rot_isolation got %0d stray valids exp 0", xfer_viol - v0); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL rot_beat got none exp %h", exp_b); end
            else begin got_b = obs_q.pop_front(); if (got_b !== exp_b) begin errors++; $display("[TB] FAIL rot_beat got %h exp %h", got_b, exp_b); end end
        end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL rot_extra got %0d beats exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_burst_stalls();
        bit ok;
        int v0;
        @(posedge clk); #1;
        v0 = xfer_viol;
        r_stall_rand = 1'b1; rdy_rand = 1'b1;
        req_addr[2] = 32'h3000_0000; req_len[2] = 8'd3; req_left[2] = 1;
        req_addr[3] = 32'h4000_0000; req_len[3] = 8'd3; req_left[3] = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(make_beat(2, 32'h3000_0000, i, i == 3, 1'b0));
        for (int i = 0; i < 4; i++) exp_q.push_back(make_beat(3, 32'h4000_0000, i, i == 3, 1'b0));
        wait_drain(ok);
        r_stall_rand = 1'b0; rdy_rand = 1'b0;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout got busy %b exp idle", busy_o); end
        checks++; if (xfer_viol - v0 !== 0) begin errors++; $display("[TB] FAIL stall_isolation got %0d stray valids exp 0", xfer_viol - v0); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL stall_beat got none exp %h", exp_b); end
            else begin got_b = obs_q.pop_front(); if (got_b !== exp_b) begin errors++; $display("[TB] FAIL stall_beat got %h exp %h", got_b, exp_b); end end
        end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL stall_extra got %0d beats exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_len_err();
        bit ok;
        int lerr0;
        // len=1 but rlast on the first beat
        @(posedge clk); #1;
        lerr0 = lerr_cnt;
        last_override = 1;
        req_addr[1] = 32'h5000_0000; req_len[1] = 8'd1; req_left[1] = 1;
        exp_q.push_back(make_beat(1, 32'h5000_0000, 0, 1'b1, 1'b1));
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL lerr_short_timeout got busy %b exp idle", busy_o); end
        checks++; if (lerr_cnt - lerr0 !== 1) begin errors++; $display("[TB] FAIL lerr_short_pulses got %0d exp 1", lerr_cnt - lerr0); end
        // len=0 but rlast only on the second beat
        @(posedge clk); #1;
        lerr0 = lerr_cnt;
        last_override = 2;
        req_addr[1] = 32'h5100_0000; req_len[1] = 8'd0; req_left[1] = 1;
        exp_q.push_back(make_beat(1, 32'h5100_0000, 0, 1'b0, 1'b1));
        exp_q.push_back(make_beat(1, 32'h5100_0000, 1, 1'b1, 1'b1));
        wait_drain(ok);
        last_override = 0;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL lerr_long_timeout got busy %b exp idle", busy_o); end
        checks++; if (lerr_cnt - lerr0 !== 2) begin errors++; $display("[TB] FAIL lerr_long_pulses got %0d exp 2", lerr_cnt - lerr0); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL lerr_beat got none exp %h", exp_b); end
            else begin got_b = obs_q.pop_front(); if (got_b !== exp_b) begin errors++; $display("[TB] FAIL lerr_beat got %h exp %h", got_b, exp_b); end end
        end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL lerr_extra got %0d beats exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n0, g1, g2, gap;
        @(posedge clk); #1;
        n0 = ar_order.size();
        req_addr[1] = 32'h6000_0000; req_len[1] = 8'd3; req_left[1] = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(make_beat(1, 32'h6000_0000, i, i == 3, 1'b0));
        wait_ar(n0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_ar_timeout got %0d grants exp %0d", ar_order.size(), n0 + 1); end
        req_addr[2] = 32'h7000_0000; req_len[2] = 8'd0; req_left[2] = 1;
        exp_q.push_back(make_beat(2, 32'h7000_0000, 0, 1'b1, 1'b0));
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout got busy %b exp idle", busy_o); end
        g1  = (ar_order.size() > n0) ? ar_order[n0] : -1;
        g2  = (ar_order.size() > n0 + 1) ? ar_order[n0 + 1] : -1;
        gap = (ar_cyc.size() > n0 + 1) ? ar_cyc[n0 + 1] - r_last_cyc[1] : -1;
        checks++; if (g1 !== 1 || g2 !== 2) begin errors++; $display("[TB] FAIL b2b_order got %0d,%0d exp 1,2", g1, g2); end
        checks++; if (gap !== 2) begin errors++; $display("[TB] FAIL b2b_gap got %0d cycles exp 2", gap); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL b2b_beat got none exp %h", exp_b); end
            else begin got_b = obs_q.pop_front(); if (got_b !== exp_b) begin errors++; $display("[TB] FAIL b2b_beat got %h exp %h", got_b, exp_b); end end
        end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL b2b_extra got %0d beats exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int n0, g;
        // finish a master 1 burst first so a surviving pointer would favour master 2
        @(posedge clk); #1;
        req_addr[1] = 32'h9000_0000; req_len[1] = 8'd0; req_left[1] = 1;
        exp_q.push_back(make_beat(1, 32'h9000_0000, 0, 1'b1, 1'b0));
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_pre_timeout got busy %b exp idle", busy_o); end
        rdy_hold[3] = 1'b1;
        n0 = ar_order.size();
        req_addr[3] = 32'hA000_0000; req_len[3] = 8'd3; req_left[3] = 1;
        wait_ar(n0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_ar_timeout got %0d grants exp %0d", ar_order.size(), n0 + 1); end
        @(posedge clk); #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rmid_in_burst got busy %b exp 1", busy_o); end
        rst_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got %b exp 0", busy_o); end
        checks++; if (s_r_valid_o !== 4'b0 || m_r_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_r got valid %b ready %b exp 0000 0", s_r_valid_o, m_r_ready_o); end
        checks++; if (s_ar_ready_o !== 4'b0 || m_ar_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ar got ready %b valid %b exp 0000 0", s_ar_ready_o, m_ar_valid_o); end
        rst_i = 1'b1;
        rdy_hold[3] = 1'b0;
        n0 = ar_order.size();
        req_addr[0] = 32'hB000_0000; req_len[0] = 8'd0; req_left[0] = 1;
        req_addr[2] = 32'hC000_0000; req_len[2] = 8'd0; req_left[2] = 1;
        exp_q.push_back(make_beat(0, 32'hB000_0000, 0, 1'b1, 1'b0));
        exp_q.push_back(make_beat(2, 32'hC000_0000, 0, 1'b1, 1'b0));
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_post_timeout got busy %b exp idle", busy_o); end
        g = (ar_order.size() > n0) ? ar_order[n0] : -1;
        checks++; if (g !== 0) begin errors++; $display("[TB] FAIL rmid_first_grant got %0d exp 0", g); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL rmid_beat got none exp %h", exp_b); end
            else begin got_b = obs_q.pop_front(); if (got_b !== exp_b) begin errors++; $display("[TB] FAIL rmid_beat got %h exp %h", got_b, exp_b); end end
        end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL rmid_extra got %0d beats exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got no finish exp finish by 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_burst_stalls();
        test_len_err();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
